reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
Parametrised reset controller for the audio top level. It replaces the single-button, single-reset inline sequencer with one that merges N synchronised and debounced reset sources plus a software request. It holds every reset domain until all sources are released, stretches reset for a programmable time, then releases the domains in a staggered order. It also reports the reset cause and an event count for debug LEDs and extension pins.

Parameters:
NUM_SOURCES, 2, number of asynchronous reset source inputs (board button, extension button, ...)
SRC_ACTIVE_LOW, 2'b10, per-source polarity mask; bit k = 1 means source k asserts when low
DEBOUNCE_CLKS, 4, consecutive identical synchronised samples needed to change a debounced level (>= 1)
RESET_CLKS, 7, cycles spent in IN_PROGRESS (>= 1)
NUM_DOMAINS, 3, number of reset outputs; domain 0 is released first
STAGGER_CLKS, 2, cycles between consecutive domain releases (>= 1)

Ports:
clk_i  input  1  single clock for the block
reset_i  input  1  synchronous, active-high reset (power-on / global)
rst_src_i  input  NUM_SOURCES  raw asynchronous reset requests (button pins)
sw_reset_i  input  1  synchronous single-cycle software reset request
reset_o  output  NUM_DOMAINS  active-high reset per domain, registered
reset_busy_o  output  1  high while any reset_o bit is high
led_reset_o  output  1  reset indicator LED; equals reset_busy_o
reset_cause_o  output  NUM_SOURCES+1  sticky cause of last reset; bit k = source k, bit NUM_SOURCES = sw request
reset_count_o  output  8  number of reset events since reset_i, saturating at 255

Behaviour:
- Reset (reset_i sampled high):
  - reset_o = all ones; reset_busy_o = 1; led_reset_o = 1.
  - reset_cause_o = 0; reset_count_o = 0.
  - State = BEGIN; debouncer levels = 0; synchroniser flops = 0.
- Source path, per source:
  - Two-flop synchroniser, then polarity normalisation via SRC_ACTIVE_LOW.
  - Debouncer changes its level on the edge at which the DEBOUNCE_CLKS-th consecutive opposite sample is taken.
  - Any differing sample restarts the count.
  - Latency from pin change to debounced change = 2 + DEBOUNCE_CLKS edges.
- Request = OR of all debounced levels, or sw_reset_i when state is RUNNING. sw_reset_i is ignored in every other state.
- FSM states: BEGIN, WAIT_RELEASE, IN_PROGRESS, RELEASE, RUNNING. All outputs are registered.
  - BEGIN: all reset_o high; always goes to WAIT_RELEASE on the next edge.
  - WAIT_RELEASE: stays while any debounced source is asserted. Otherwise loads the counter and goes to IN_PROGRESS.
  - IN_PROGRESS: lasts exactly RESET_CLKS cycles. On the edge leaving it, reset_o[0] <= 0 and state = RELEASE.
  - RELEASE: reset_o[d] falls d*STAGGER_CLKS edges after reset_o[0]. On the edge where reset_o[NUM_DOMAINS-1] falls, state = RUNNING and reset_busy_o / led_reset_o fall.
  - If NUM_DOMAINS = 1, IN_PROGRESS goes straight to RUNNING.
  - RUNNING: on the edge a request is sampled:
    - state = BEGIN and reset_o = all ones.
    - reset_cause_o is overwritten with the request bits of that cycle.
    - reset_count_o increments, saturating.
- Restart: a debounced source asserting during IN_PROGRESS or RELEASE has these effects:
  - returns to BEGIN and re-asserts all domains on the same edge;
  - ORs the source bit into reset_cause_o;
  - increments reset_count_o.
- Simultaneous requests: all bits are recorded and a single count increment is made.
- Power-on sequence after reset_i falls: runs without incrementing the count; cause stays 0.
- No reset_o bit ever falls while any higher-indexed bit is low (monotonic release order).

Decomposition:
- Package reset_seq_pkg holds:
  - the state enum (3-bit, encodings 0–4 in the order listed);
  - the cause bit index localparams (CAUSE_SW = NUM_SOURCES computed in the module);
  - the count width (8).
- Sub-module reset_debounce: one instance per source, generated. Contains the 2-flop synchroniser, polarity inversion and debounce counter. Ports: clk_i, reset_i, raw_i, level_o.

Test Plan (defaults: DEBOUNCE_CLKS 4, RESET_CLKS 7, NUM_DOMAINS 3, STAGGER_CLKS 2):
- Power-on: reset_i high 3 cycles, then low, sources idle -> reset_o[0] falls on the 9th edge after reset_i low, reset_o[1] on the 11th, reset_o[2] on the 13th; busy/led fall on the 13th; cause = 0, count = 0.
- Button: after RUNNING, rst_src_i[0] high 20 cycles -> reset_o = 3'b111 on the 7th edge after the pin change; held until 6 edges after the pin falls; then the 1+1+7 / +2 / +2 release; cause = 3'b001, count = 1.
- Glitch filter: rst_src_i[0] high 3 cycles, and separately rst_src_i[1] (active-low) low 3 cycles -> no reset_o change, count unchanged.
- Software reset: sw_reset_i pulsed 1 cycle in RUNNING -> reset_o = 3'b111 on the next edge, cause = 3'b100, count increments. The same pulse during RELEASE -> ignored.
- Restart: assert rst_src_i[1] low while reset_o = 3'b110 (RELEASE) -> all domains re-asserted on the debounced edge; cause = 3'b010, count +1; full sequence restarts.
- Saturation / reset: 256 software resets -> count holds at 255. reset_i pulse mid-IN_PROGRESS -> count = 0, cause = 0, sequence restarts from BEGIN.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the reset sequencer: FSM state encoding,
// event counter width and a counter-sizing helper.
package reset_seq_pkg;

    localparam int COUNT_W       = 8;
    localparam int CAUSE_SRC_LSB = 0;

    typedef enum logic [2:0] {
        ST_BEGIN        = 3'd0,
        ST_WAIT_RELEASE = 3'd1,
        ST_IN_PROGRESS  = 3'd2,
        ST_RELEASE      = 3'd3,
        ST_RUNNING      = 3'd4
    } seq_state_e;

    // Bits needed for a down/up counter spanning 0 .. n-1 (never less than one).
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == '1) ? v : v + COUNT_W'(1);
    endfunction

endpackage

// File: rtl/reset_debounce.sv
// One reset source: two-flop synchroniser, polarity normalisation and a
// debouncer that changes level after DEBOUNCE_CLKS consecutive opposite samples.
module reset_debounce
    import reset_seq_pkg::*;
#(
    parameter bit ACTIVE_LOW    = 1'b0,
    parameter int DEBOUNCE_CLKS = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic raw_i,
    output logic level_o
);

    localparam int CNT_W = cnt_width(DEBOUNCE_CLKS);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sample;

    assign sample  = sync2_q ^ ACTIVE_LOW;
    assign level_o = level_q;

    // Any sample matching the current level restarts the run count.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sample != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CLKS - 1)) begin
                level_d = sample;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Merges debounced reset sources and a software request, stretches reset and
// releases the domains in staggered order; reports cause and event count.
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int                     NUM_SOURCES    = 2,
    parameter logic [NUM_SOURCES-1:0] SRC_ACTIVE_LOW = 2'b10,
    parameter int                     DEBOUNCE_CLKS  = 4,
    parameter int                     RESET_CLKS     = 7,
    parameter int                     NUM_DOMAINS    = 3,
    parameter int                     STAGGER_CLKS   = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [NUM_SOURCES-1:0] rst_src_i,
    input  logic                   sw_reset_i,
    output logic [NUM_DOMAINS-1:0] reset_o,
    output logic                   reset_busy_o,
    output logic                   led_reset_o,
    output logic [NUM_SOURCES:0]   reset_cause_o,
    output logic [COUNT_W-1:0]     reset_count_o,
    output seq_state_e             dbg_state_o
);

    localparam int CAUSE_SW = NUM_SOURCES;
    localparam int TMR_MAX  = (RESET_CLKS > STAGGER_CLKS) ? RESET_CLKS : STAGGER_CLKS;
    localparam int TMR_W    = cnt_width(TMR_MAX);

    logic [NUM_SOURCES-1:0] level;
    seq_state_e             state_q, state_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic [NUM_DOMAINS-1:0] rst_q, rst_d, rst_shift;
    logic [NUM_SOURCES:0]   cause_q, cause_d;
    logic [COUNT_W-1:0]     count_q, count_d;
    logic                   src_req;

    for (genvar k = 0; k < NUM_SOURCES; k++) begin : g_src
        reset_debounce #(
            .ACTIVE_LOW    (SRC_ACTIVE_LOW[k]),
            .DEBOUNCE_CLKS (DEBOUNCE_CLKS)
        ) u_debounce (
            .clk_i   (clk_i),
            .reset_i (reset_i),
            .raw_i   (rst_src_i[k]),
            .level_o (level[k])
        );
    end

    assign src_req   = |level;
    // Domains release bottom-up, so each release step is a left shift of the mask.
    assign rst_shift = rst_q << 1;

    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        rst_d   = rst_q;
        cause_d = cause_q;
        count_d = count_q;
        case (state_q)
            ST_BEGIN: begin
                rst_d   = '1;
                state_d = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (!src_req) begin
                    tmr_d   = TMR_W'(RESET_CLKS - 1);
                    state_d = ST_IN_PROGRESS;
                end
            end
            ST_IN_PROGRESS, ST_RELEASE: begin
                if (src_req) begin
                    state_d = ST_BEGIN;
                    rst_d   = '1;
                    cause_d = cause_q | {1'b0, level};
                    count_d = sat_inc(count_q);
                end else if (tmr_q == '0) begin
                    rst_d   = rst_shift;
                    tmr_d   = TMR_W'(STAGGER_CLKS - 1);
                    state_d = (rst_shift == '0) ? ST_RUNNING : ST_RELEASE;
                end else begin
                    tmr_d = tmr_q - TMR_W'(1);
                end
            end
            ST_RUNNING: begin
                if (src_req || sw_reset_i) begin
                    state_d            = ST_BEGIN;
                    rst_d              = '1;
                    cause_d            = {1'b0, level};
                    cause_d[CAUSE_SW]  = sw_reset_i;
                    count_d            = sat_inc(count_q);
                end
            end
            default: begin
                state_d = ST_BEGIN;
                rst_d   = '1;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_BEGIN;
            tmr_q   <= '0;
            rst_q   <= '1;
            cause_q <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
            rst_q   <= rst_d;
            cause_q <= cause_d;
            count_q <= count_d;
        end
    end

    assign reset_o       = rst_q;
    assign reset_busy_o  = |rst_q;
    assign led_reset_o   = |rst_q;
    assign reset_cause_o = cause_q;
    assign reset_count_o = count_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus random source/sw activity,
// checked every cycle against a timeline-based reference model.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  localparam int NS = 2;
  localparam int ND = 3;
  localparam int DB = 4;
  localparam int RC = 7;
  localparam int SC = 2;
  localparam logic [NS-1:0] POL = 2'b10;
  localparam logic [NS-1:0] IDLE = POL;  // active-low pins rest high
  localparam int EW = ND + NS + 1 + 8;

  // clock / reset block
  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic sw_reset_i = 1'b0;
  logic [NS-1:0] rst_src_i = IDLE;
  logic [ND-1:0] reset_o;
  logic reset_busy_o, led_reset_o;
  logic [NS:0] reset_cause_o;
  logic [7:0] reset_count_o;
  seq_state_e dbg_state_o;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_SOURCES(NS), .SRC_ACTIVE_LOW(POL), .DEBOUNCE_CLKS(DB),
    .RESET_CLKS(RC), .NUM_DOMAINS(ND), .STAGGER_CLKS(SC)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .rst_src_i(rst_src_i), .sw_reset_i(sw_reset_i),
    .reset_o(reset_o), .reset_busy_o(reset_busy_o), .led_reset_o(led_reset_o),
    .reset_cause_o(reset_cause_o), .reset_count_o(reset_count_o), .dbg_state_o(dbg_state_o)
  );

  int n_checks = 0;
  int n_errors = 0;

  // reference model: timeline of the current sequence
  int edge_n = 0;
  int begin_at = 0;   // edge at which the sequence (re)started
  int rel_at = -1;    // edge at which domain 0 is released, -1 while unscheduled
  logic [NS-1:0] m_level = '0;
  logic [NS-1:0] raw_q[$];
  logic [NS-1:0] samp_q[$];
  int since_flip[NS];
  logic [NS:0] m_cause = '0;
  int m_count = 0;
  logic [EW-1:0] exp_q[$];

  task automatic bump_count();
    if (m_count < 255) m_count++;
  endtask

  task automatic model_step();
    logic [NS-1:0] lv, seen;
    logic [ND-1:0] e_rst;
    bit in_run, in_seq, all_diff;
    edge_n++;
    if (reset_i) begin
      begin_at = edge_n;
      rel_at = -1;
      m_cause = '0;
      m_count = 0;
      m_level = '0;
      samp_q.delete();
      raw_q.delete();
      raw_q.push_back('0);
      raw_q.push_back('0);
      for (int k = 0; k < NS; k++) since_flip[k] = 0;
    end else begin
      lv = m_level;
      in_run = (rel_at >= 0) && (edge_n > rel_at + (ND - 1) * SC);
      in_seq = (rel_at >= 0) && (edge_n > rel_at - RC) && !in_run;
      if (in_run && (lv != '0 || sw_reset_i)) begin
        begin_at = edge_n;
        rel_at = -1;
        m_cause = {sw_reset_i, lv};
        bump_count();
      end else if (in_seq && lv != '0) begin
        begin_at = edge_n;
        rel_at = -1;
        m_cause = m_cause | {1'b0, lv};
        bump_count();
      end else if (rel_at < 0 && edge_n >= begin_at + 2 && lv == '0) begin
        rel_at = edge_n + RC;
      end
      // source pins reach the debouncer two edges late
      seen = raw_q.pop_front();
      raw_q.push_back(rst_src_i);
      samp_q.push_back(seen ^ POL);
      if (samp_q.size() > DB) void'(samp_q.pop_front());
      for (int k = 0; k < NS; k++) begin
        since_flip[k]++;
        if (since_flip[k] >= DB) begin
          all_diff = 1'b1;
          for (int i = 0; i < DB; i++)
            if (samp_q[samp_q.size() - 1 - i][k] == m_level[k]) all_diff = 1'b0;
          if (all_diff) begin
            m_level[k] = ~m_level[k];
            since_flip[k] = 0;
          end
        end
      end
    end
    for (int d = 0; d < ND; d++)
      e_rst[d] = !((rel_at >= 0) && (edge_n >= rel_at + d * SC));
    exp_q.push_back({e_rst, m_cause, 8'(m_count)});
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h edge=%0d", tag, obs, exp, edge_n);
    end
  endtask

  // driver: one clock edge, model update, scoreboard compare
  task automatic tick();
    logic [EW-1:0] e;
    @(posedge clk);
    #1;
    model_step();
    e = exp_q.pop_front();
    check("reset_o", 32'(reset_o), 32'(e[EW-1 -: ND]));
    check("busy", 32'(reset_busy_o), 32'(|e[EW-1 -: ND]));
    check("led", 32'(led_reset_o), 32'(|e[EW-1 -: ND]));
    check("cause", 32'(reset_cause_o), 32'(e[8 +: NS+1]));
    check("count", 32'(reset_count_o), 32'(e[7:0]));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic sw_pulse();
    sw_reset_i = 1'b1;
    tick();
    sw_reset_i = 1'b0;
  endtask

  task automatic src_pulse(input logic [NS-1:0] mask, input int len);
    rst_src_i = IDLE ^ mask;
    ticks(len);
    rst_src_i = IDLE;
  endtask

  initial begin
    // power-on
    reset_i = 1'b1;
    ticks(3);
    check("por_reset_o", 32'(reset_o), 32'h7);
    check("por_count", 32'(reset_count_o), 32'h0);
    reset_i = 1'b0;
    for (int i = 1; i <= 13; i++) begin
      tick();
      if (i == 8) check("por_e8", 32'(reset_o), 32'h7);
      if (i == 9) check("por_e9", 32'(reset_o), 32'h6);
      if (i == 11) check("por_e11", 32'(reset_o), 32'h4);
      if (i == 13) check("por_e13", 32'({reset_busy_o, reset_o}), 32'h0);
    end
    ticks(3);

    // button on source 0
    rst_src_i = IDLE ^ 2'b01;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 6) check("btn_e6", 32'(reset_o), 32'h0);
      if (i == 7) check("btn_e7", 32'(reset_o), 32'h7);
    end
    rst_src_i = IDLE;
    ticks(30);
    check("btn_cause", 32'(reset_cause_o), 32'h1);
    check("btn_count", 32'(reset_count_o), 32'h1);

    // glitch filter on both polarities
    src_pulse(2'b01, 3);
    ticks(10);
    src_pulse(2'b10, 3);
    ticks(12);
    check("glitch_count", 32'(reset_count_o), 32'h1);
    check("glitch_reset_o", 32'(reset_o), 32'h0);

    // software reset, then a pulse during RELEASE that must be ignored
    sw_pulse();
    check("sw_reset_o", 32'(reset_o), 32'h7);
    check("sw_cause", 32'(reset_cause_o), 32'h4);
    check("sw_count", 32'(reset_count_o), 32'h2);
    ticks(10);
    check("sw_release", 32'(reset_o), 32'h6);
    sw_pulse();
    ticks(20);
    check("sw_ign_count", 32'(reset_count_o), 32'h2);

    // random activity
    for (int it = 0; it < 120; it++) begin
      case ($urandom_range(0, 3))
        0: src_pulse(($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01, $urandom_range(1, 10));
        1: sw_pulse();
        2: ticks($urandom_range(1, 15));
        default: src_pulse(2'b11, $urandom_range(3, 9));
      endcase
    end
    rst_src_i = IDLE;
    ticks(40);

    // saturation
    for (int i = 0; i < 256; i++) begin
      sw_pulse();
      ticks(13);
    end
    check("sat_count", 32'(reset_count_o), 32'd255);
    ticks(2);

    // reset_i mid IN_PROGRESS, then restart during RELEASE from source 1
    sw_pulse();
    ticks(5);
    reset_i = 1'b1;
    tick();
    check("rst_count", 32'(reset_count_o), 32'h0);
    check("rst_cause", 32'(reset_cause_o), 32'h0);
    reset_i = 1'b0;
    ticks(4);
    rst_src_i = IDLE ^ 2'b10;
    for (int i = 5; i <= 14; i++) begin
      tick();
      if (i == 9) check("rs_e9", 32'(reset_o), 32'h6);
      if (i == 12) check("rs_e12", 32'(reset_o), 32'h7);
    end
    rst_src_i = IDLE;
    ticks(30);
    check("rs_cause", 32'(reset_cause_o), 32'h2);
    check("rs_count", 32'(reset_count_o), 32'h1);
    check("rs_done", 32'(reset_o), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
